// File: rtl/fifo_ram.sv
// Storage array for sync_fifo.
// 2**ADDR_WIDTH x DATA_WIDTH entries, one synchronous write port and one
// asynchronous (combinational) read port, so the FIFO head is visible in the
// same cycle its read pointer moves.
module fifo_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Write port: capture the entry on the rising edge when enabled.
  // NOTE: the array has no reset; the pointers alone decide which entries are
  // valid, and leaving it unreset lets it map onto plain RAM/register files.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port: combinational lookup of the addressed entry.
  always_comb begin
    rdata_o = mem_q[raddr_i];
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
// Depth 2**ADDR_WIDTH, DATA_WIDTH-bit entries. Pointers carry one extra wrap
// bit so full and empty are distinguishable without a separate counter.
// Optional feature: define SYNC_FIFO_COUNT_EN to add the o_count occupancy
// output; without it the port and its logic are absent.
module sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  i_wen,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_ren,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_empty,
  output logic                  o_full
`ifdef SYNC_FIFO_COUNT_EN
  ,
  output logic [ADDR_WIDTH:0]   o_count
`endif
);

  localparam int PTR_W = ADDR_WIDTH + 1;

  logic [PTR_W-1:0]      wptr_q, wptr_d;
  logic [PTR_W-1:0]      rptr_q, rptr_d;
  logic                  empty, full;
  logic                  wr_fire, rd_fire;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Flags straight from the registered pointers: equal means empty; same slot
  // but opposite wrap bit means the writer is a full lap ahead.
  always_comb begin
    empty = (wptr_q == rptr_q);
    full  = (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]) &&
            (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]);
  end

  // Qualify requests: writes are dropped when full, reads ignored when empty.
  // A simultaneous write on empty therefore only writes (no bypass), and a
  // simultaneous read on full only reads.
  always_comb begin
    wr_fire = i_wen && !full;
    rd_fire = i_ren && !empty;
  end

  // Next-state pointers, wrapping naturally modulo 2**PTR_W.
  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_fire) begin
      wptr_d = wptr_q + PTR_W'(1);
    end
    if (rd_fire) begin
      rptr_d = rptr_q + PTR_W'(1);
    end
  end

  // Pointer registers; asynchronous reset empties the FIFO immediately.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_fire),
    .waddr_i (wptr_q[ADDR_WIDTH-1:0]),
    .wdata_i (i_data),
    .raddr_i (rptr_q[ADDR_WIDTH-1:0]),
    .rdata_o (ram_rdata)
  );

  // Outputs: head entry is forced to zero while empty so stale RAM contents
  // never leak out.
  always_comb begin
    o_empty = empty;
    o_full  = full;
    o_data  = empty ? '0 : ram_rdata;
  end

`ifdef SYNC_FIFO_COUNT_EN
  // Occupancy: pointer difference modulo 2**PTR_W, range 0..2**ADDR_WIDTH.
  always_comb begin
    o_count = wptr_q - rptr_q;
  end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (DATA_WIDTH=32, ADDR_WIDTH=3).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_sync_fifo;

  localparam int DW = 32;
  localparam int AW = 3;

  logic          clk;
  logic          rst_n;
  logic          wen;
  logic          ren;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          empty;
  logic          full;
`ifdef SYNC_FIFO_COUNT_EN
  logic [AW:0]   count;
`endif

  int n_total  = 0;
  int n_passed = 0;

  sync_fifo #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk     (clk),
    .i_rst_n (rst_n),
    .i_wen   (wen),
    .i_data  (wdata),
    .i_ren   (ren),
    .o_data  (rdata),
    .o_empty (empty),
    .o_full  (full)
`ifdef SYNC_FIFO_COUNT_EN
    ,
    .o_count (count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_count(input string tag, input int exp);
`ifdef SYNC_FIFO_COUNT_EN
    check(tag, DW'(count), DW'(exp));
`else
    if (exp < 0) $display("unused %s", tag);
`endif
  endtask

  initial begin
    rst_n = 1'b1;
    wen   = 1'b0;
    ren   = 1'b0;
    wdata = '0;

    // Asynchronous reset asserted between clock edges takes effect at once.
    #2 rst_n = 1'b0;
    #1;
    check("rst_empty", DW'(empty), 1);
    check("rst_full",  DW'(full),  0);
    check("rst_data",  rdata,      0);
    check_count("rst_count", 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single write then single read.
    wen = 1'b1; wdata = 32'hA1;
    tick();
    wen = 1'b0;
    check("a1_empty", DW'(empty), 0);
    check("a1_data",  rdata,      32'hA1);
    ren = 1'b1;
    tick();
    ren = 1'b0;
    check("a1_pop_empty", DW'(empty), 1);
    check("a1_pop_data",  rdata,      0);

    // Fill with 0..7, full asserts only after the eighth write.
    for (int i = 0; i < 8; i++) begin
      wen = 1'b1; wdata = DW'(i);
      tick();
      check("fill_full", DW'(full), (i == 7) ? 1 : 0);
    end
    check_count("fill_count", 8);
    // Ninth write is ignored.
    wdata = 32'hFF;
    tick();
    wen = 1'b0;
    check("ovf_full", DW'(full), 1);
    check("ovf_head", rdata,     0);
    check_count("ovf_count", 8);
    // Drain in order.
    for (int i = 0; i < 8; i++) begin
      check("drain_data", rdata, DW'(i));
      ren = 1'b1;
      tick();
    end
    ren = 1'b0;
    check("drain_empty", DW'(empty), 1);
    check("drain_zero",  rdata,      0);
    // Read on empty is ignored: still empty after another request.
    ren = 1'b1;
    tick();
    ren = 1'b0;
    check("udf_empty", DW'(empty), 1);
    check_count("udf_count", 0);

    // Full with simultaneous write+read: read only, write data dropped.
    for (int i = 0; i < 8; i++) begin
      wen = 1'b1; wdata = 32'h10 + DW'(i);
      tick();
    end
    check("sim_pre_full", DW'(full), 1);
    wen = 1'b1; ren = 1'b1; wdata = 32'h55;
    tick();
    wen = 1'b0; ren = 1'b0;
    check("sim_full",  DW'(full), 0);
    check("sim_head",  rdata,     32'h11);
    check_count("sim_count", 7);
    for (int i = 1; i < 8; i++) begin
      check("sim_drain", rdata, 32'h10 + DW'(i));
      ren = 1'b1;
      tick();
    end
    ren = 1'b0;
    check("sim_drop_empty", DW'(empty), 1);

    // Steady state at 4 entries with concurrent write+read across wraps.
    for (int i = 0; i < 4; i++) begin
      wen = 1'b1; wdata = 32'h20 + DW'(i);
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      check("steady_head", rdata, 32'h20 + DW'(i));
      wen = 1'b1; ren = 1'b1; wdata = 32'h24 + DW'(i);
      tick();
      check("steady_empty", DW'(empty), 0);
      check("steady_full",  DW'(full),  0);
    end
    wen = 1'b0; ren = 1'b0;
    check_count("steady_count", 4);
    for (int i = 0; i < 4; i++) begin
      check("steady_drain", rdata, 32'h34 + DW'(i));
      ren = 1'b1;
      tick();
    end
    ren = 1'b0;
    check("steady_end_empty", DW'(empty), 1);

    // Read on empty with write: the write lands, no bypass.
    wen = 1'b1; ren = 1'b1; wdata = 32'hBEEF;
    tick();
    ren = 1'b0;
    check("wr_on_empty_empty", DW'(empty), 0);
    check("wr_on_empty_data",  rdata,      32'hBEEF);
    wdata = 32'hC0;
    tick();
    wdata = 32'hC1;
    tick();
    wen = 1'b0;
    check_count("three_count", 3);
    check("three_head", rdata, 32'hBEEF);

    // Mid-operation reset discards contents without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("midrst_empty", DW'(empty), 1);
    check("midrst_full",  DW'(full),  0);
    check("midrst_data",  rdata,      0);
    check_count("midrst_count", 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_empty", DW'(empty), 1);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
